key_entry_buffer: RTL and testbench
===================================

// Module: key_entry_buffer
// PURPOSE
//  - Downstream of the 4x4 keypad scanner. Consumes one-cycle key events (key_valid + 4-bit key_code).
//  - Assembles decimal digits into a multi-digit entry and supports backspace, clear and enter.
//  - On enter, converts the BCD entry to binary over several cycles and emits a one-cycle num_valid.
//  - The live BCD digits feed the seven-segment display; the committed value feeds the datapath.
// PARAMETERS
//  - MAX_DIGITS  4   maximum number of digits held in the entry buffer
//  - VAL_W       14  width of num_value; must hold 10^MAX_DIGITS-1
//  - CNT_W       3   width of digit_cnt; must hold MAX_DIGITS
// PORTS
//  - clk          in   1               system clock; the block's only clock
//  - rst          in   1               synchronous, active-high reset
//  - key_valid    in   1               one-cycle strobe: key_code is a new key event
//  - key_code     in   4               0-9 digit, A clear, B sign (feature), C/D ignored, E backspace, F enter
//  - bcd_digits   out  4*MAX_DIGITS    live entry; [3:0] = least-significant (most recently typed) digit
//  - digit_cnt    out  CNT_W           number of digits currently entered (0..MAX_DIGITS)
//  - busy         out  1               high while in CONVERT
//  - num_valid    out  1               one-cycle pulse: num_value is updated
//  - num_value    out  VAL_W           last committed binary value; held between commits
//  - num_neg      out  1               sign of last committed value (tied 0 without SIGNED_ENTRY_EN)
// BEHAVIOUR
//  - Reset (rst=1 at a clk edge): all outputs 0, state ENTRY. Reset in CONVERT aborts it; no num_valid is produced.
//  - States:
//      ENTRY:   accepts keys.
//      CONVERT: digit_cnt cycles; key events are dropped.
//      DONE:    1 cycle; num_valid=1, then return to ENTRY.
//  - ENTRY, digit key with digit_cnt<MAX_DIGITS: bcd_digits <= {bcd_digits<<4 | code}; digit_cnt+1. Takes effect the next cycle.
//  - ENTRY, digit key with digit_cnt==MAX_DIGITS: dropped; buffer unchanged.
//  - Leading zeros are accepted and counted as digits.
//  - E (backspace): bcd_digits >> 4 with zero fill at the top; digit_cnt-1. No effect when digit_cnt==0.
//  - A (clear): bcd_digits=0, digit_cnt=0, entry sign=0. num_value is untouched.
//  - F (enter) with digit_cnt==0: ignored.
//  - F (enter) with digit_cnt>0, accepted at edge T:
//      - Latch the digit count and sign; clear acc.
//      - CONVERT runs edges T+1..T+n (n = latched count). Each edge: acc <= acc*10 + digit[i], i from n-1 down to 0.
//      - acc*10 is formed as (acc<<3)+(acc<<1), truncated to VAL_W.
//      - Edge T+n+1: num_value <= acc, num_neg <= sign, num_valid=1 for that one cycle.
//      - The buffer clears at the same edge: bcd_digits=0, digit_cnt=0.
//      - Total latency from the enter edge to the num_valid edge = n+1 cycles. busy=1 for exactly n cycles.
//  - bcd_digits stays visible (unchanged) during CONVERT.
//  - Key events in CONVERT or DONE are lost. The producer is not back-pressured.
//  - key_valid held high for several cycles is treated as that many events; upstream guarantees one-cycle pulses.
//  - C, D: no effect in any state.
// CONFIGURATION
//  - SIGNED_ENTRY_EN defined:
//      - Key B in ENTRY toggles the entry sign.
//      - On commit, num_value = two's complement of the magnitude if sign=1; num_neg = sign.
//      - A negative zero commits as 0 with num_neg=0.
//      - Sign resets to 0 on clear, on commit, and on reset.
//  - SIGNED_ENTRY_EN undefined:
//      - Key B is ignored. num_neg is tied 0. num_value is unsigned magnitude.
// TESTING
//  - Keys 1,2,3,F: bcd_digits=0x0123, digit_cnt=3 before enter; busy 3 cycles; num_valid at enter+4; num_value=123; digit_cnt=0.
//  - Keys 9,8,7,6,5,F: fifth digit dropped; num_value=9876; num_valid at enter+5.
//  - Keys 4,5,E,7,F: bcd_digits goes 0x04 -> 0x45 -> 0x04 -> 0x47; num_value=47.
//  - Keys 3,A,F: clear empties the buffer; enter is ignored; no num_valid; num_value keeps its previous value.
//  - Keys 1,2,F, then rst at enter+1: no num_valid; all outputs 0. Next keys 5,F -> num_value=5.
//  - With SIGNED_ENTRY_EN: keys B,2,5,F -> num_neg=1, num_value=-25 (14'h3FE7).
//  - Without SIGNED_ENTRY_EN: same keys -> num_neg=0, num_value=25.

Source files
------------

// File: rtl/key_entry_buffer.sv
// Keypad entry buffer: collects decimal digits, then converts the BCD entry to binary on enter.
// Optional signed entry (key B toggles sign) is enabled by defining SIGNED_ENTRY_EN.
module key_entry_buffer #(
   parameter int MAX_DIGITS = 4,
   parameter int VAL_W      = 14,
   parameter int CNT_W      = 3
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    key_valid,
   input  logic [3:0]              key_code,
   output logic [4*MAX_DIGITS-1:0] bcd_digits,
   output logic [CNT_W-1:0]        digit_cnt,
   output logic                    busy,
   output logic                    num_valid,
   output logic [VAL_W-1:0]        num_value,
   output logic                    num_neg
);

   typedef enum logic [1:0] {ENTRY, CONVERT, DONE} state_t;

   state_t           state;
   state_t           state_next;
   logic [CNT_W-1:0] conv_idx;
   logic [CNT_W-1:0] dig_sel;
   logic [3:0]       conv_digit;
   logic [VAL_W-1:0] acc;
   logic [VAL_W-1:0] acc_next;
   logic             enter_go;

`ifdef SIGNED_ENTRY_EN
   logic sign;
   logic conv_sign;
`endif

   assign enter_go = (state == ENTRY) && key_valid && (key_code == 4'hF) && (digit_cnt != '0);

   always_comb begin
      state_next = state;
      busy       = 1'b0;
      case (state)
         ENTRY:   if (enter_go) state_next = CONVERT;
         CONVERT: begin
            busy = 1'b1;
            if (conv_idx == CNT_W'(1)) state_next = DONE;
         end
         DONE:    state_next = ENTRY;
         default: state_next = ENTRY;
      endcase
   end

   // conv_idx counts remaining digits, so the most significant unconverted digit sits at conv_idx-1
   always_comb begin
      dig_sel    = conv_idx - CNT_W'(1);
      conv_digit = 4'h0;
      for (int i = 0; i < MAX_DIGITS; i++) begin
         if (dig_sel == CNT_W'(i)) conv_digit = bcd_digits[4*i +: 4];
      end
      acc_next = (acc << 3) + (acc << 1) + VAL_W'(conv_digit);
   end

   always_ff @(posedge clk) begin
      if (rst) state <= ENTRY;
      else     state <= state_next;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bcd_digits <= '0;
         digit_cnt  <= '0;
         num_valid  <= 1'b0;
         num_value  <= '0;
         conv_idx   <= '0;
         acc        <= '0;
`ifdef SIGNED_ENTRY_EN
         sign       <= 1'b0;
         conv_sign  <= 1'b0;
         num_neg    <= 1'b0;
`endif
      end else begin
         num_valid <= 1'b0;
         case (state)
            ENTRY: begin
               if (key_valid) begin
                  case (key_code)
                     4'hA: begin
                        bcd_digits <= '0;
                        digit_cnt  <= '0;
`ifdef SIGNED_ENTRY_EN
                        sign       <= 1'b0;
`endif
                     end
`ifdef SIGNED_ENTRY_EN
                     4'hB: sign <= ~sign;
`endif
                     4'hE: begin
                        if (digit_cnt != '0) begin
                           bcd_digits <= {4'h0, bcd_digits[4*MAX_DIGITS-1:4]};
                           digit_cnt  <= digit_cnt - CNT_W'(1);
                        end
                     end
                     4'hF: begin
                        if (digit_cnt != '0) begin
                           conv_idx  <= digit_cnt;
                           acc       <= '0;
`ifdef SIGNED_ENTRY_EN
                           conv_sign <= sign;
`endif
                        end
                     end
                     default: begin
                        if ((key_code <= 4'd9) && (digit_cnt < CNT_W'(MAX_DIGITS))) begin
                           bcd_digits <= {bcd_digits[4*MAX_DIGITS-5:0], key_code};
                           digit_cnt  <= digit_cnt + CNT_W'(1);
                        end
                     end
                  endcase
               end
            end
            CONVERT: begin
               acc      <= acc_next;
               conv_idx <= conv_idx - CNT_W'(1);
            end
            DONE: begin
               num_valid  <= 1'b1;
               bcd_digits <= '0;
               digit_cnt  <= '0;
`ifdef SIGNED_ENTRY_EN
               // two's complement of zero is zero, so only the sign flag needs the zero guard
               num_value  <= conv_sign ? (~acc + VAL_W'(1)) : acc;
               num_neg    <= conv_sign && (acc != '0);
               sign       <= 1'b0;
`else
               num_value  <= acc;
`endif
            end
            default: ;
         endcase
      end
   end

`ifndef SIGNED_ENTRY_EN
   assign num_neg = 1'b0;
`endif

endmodule

// File: tb/tb_key_entry_buffer.sv
// Self-checking bench for key_entry_buffer: directed keypad scenarios plus random key traffic
// compared every cycle against a queue-based reference model.
module tb_key_entry_buffer;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        key_valid = 1'b0;
   logic [3:0]  key_code = 4'h0;
   logic [15:0] bcd_digits;
   logic [2:0]  digit_cnt;
   logic        busy;
   logic        num_valid;
   logic [13:0] num_value;
   logic        num_neg;

   int checkCount = 0;
   int errorCount = 0;

   int digQ[$];
   int mSign = 0;
   int mWait = 0;
   int mVal = 0;
   int mNeg = 0;
   int mValid = 0;
   int pendVal = 0;
   int pendNeg = 0;

   key_entry_buffer dut (
      .clk        (clk),
      .rst        (rst),
      .key_valid  (key_valid),
      .key_code   (key_code),
      .bcd_digits (bcd_digits),
      .digit_cnt  (digit_cnt),
      .busy       (busy),
      .num_valid  (num_valid),
      .num_value  (num_value),
      .num_neg    (num_neg)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checkCount++;
      if (got !== exp) begin
         errorCount++;
         $display("[TB] FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference: digits kept as a queue of ints, the value computed in plain decimal arithmetic
   task automatic modelStep(input logic v, input logic [3:0] code, input logic r);
      int mag;
      mValid = 0;
      if (r) begin
         digQ.delete();
         mSign = 0; mWait = 0; mVal = 0; mNeg = 0;
      end else if (mWait > 0) begin
         mWait--;
         if (mWait == 0) begin
            mVal = pendVal; mNeg = pendNeg; mValid = 1;
            digQ.delete();
            mSign = 0;
         end
      end else if (v) begin
         if (code <= 4'd9) begin
            if (digQ.size() < 4) digQ.push_back(int'(code));
         end else if (code == 4'hA) begin
            digQ.delete();
            mSign = 0;
         end else if (code == 4'hB) begin
`ifdef SIGNED_ENTRY_EN
            mSign = 1 - mSign;
`endif
         end else if (code == 4'hE) begin
            if (digQ.size() > 0) void'(digQ.pop_back());
         end else if (code == 4'hF) begin
            if (digQ.size() > 0) begin
               mag = 0;
               foreach (digQ[i]) mag = mag * 10 + digQ[i];
               if (mSign == 1 && mag != 0) begin
                  pendVal = 16384 - mag; pendNeg = 1;
               end else begin
                  pendVal = mag; pendNeg = 0;
               end
               mWait = digQ.size() + 1;
            end
         end
      end
   endtask

   function automatic int expBcd();
      int b = 0;
      foreach (digQ[i]) b = b * 16 + digQ[i];
      return b;
   endfunction

   task automatic applyStimulus(input logic v, input logic [3:0] code, input logic r);
      @(negedge clk);
      key_valid = v;
      key_code  = code;
      rst       = r;
      @(posedge clk);
      modelStep(v, code, r);
      #1;
      checkOutput("bcd_digits", 32'(bcd_digits), 32'(expBcd()));
      checkOutput("digit_cnt", 32'(digit_cnt), 32'(digQ.size()));
      checkOutput("busy", 32'(busy), 32'(mWait >= 2));
      checkOutput("num_valid", 32'(num_valid), 32'(mValid));
      checkOutput("num_value", 32'(num_value), 32'(mVal));
      checkOutput("num_neg", 32'(num_neg), 32'(mNeg));
   endtask

   task automatic pressKey(input logic [3:0] code);
      applyStimulus(1'b1, code, 1'b0);
   endtask

   // Returns the number of idle cycles after the enter edge until num_valid is seen, or -1
   task automatic waitValid(output int lat);
      lat = -1;
      for (int k = 1; k <= 12; k++) begin
         applyStimulus(1'b0, 4'h0, 1'b0);
         if (num_valid) begin
            lat = k;
            break;
         end
      end
   endtask

   initial begin
      int lat;
      int sawValid;
      int r;

      applyStimulus(1'b0, 4'h0, 1'b1);
      applyStimulus(1'b0, 4'h0, 1'b1);
      checkOutput("rst_value", 32'(num_value), 32'd0);
      applyStimulus(1'b0, 4'h0, 1'b0);

      pressKey(4'h1); pressKey(4'h2); pressKey(4'h3);
      checkOutput("bcd_123", 32'(bcd_digits), 32'h0123);
      checkOutput("cnt_123", 32'(digit_cnt), 32'd3);
      pressKey(4'hF);
      waitValid(lat);
      checkOutput("lat_123", 32'(lat), 32'd4);
      checkOutput("val_123", 32'(num_value), 32'd123);
      checkOutput("cnt_after", 32'(digit_cnt), 32'd0);

      pressKey(4'h9); pressKey(4'h8); pressKey(4'h7); pressKey(4'h6); pressKey(4'h5);
      checkOutput("bcd_9876", 32'(bcd_digits), 32'h9876);
      pressKey(4'hF);
      waitValid(lat);
      checkOutput("lat_9876", 32'(lat), 32'd5);
      checkOutput("val_9876", 32'(num_value), 32'd9876);

      pressKey(4'h4);
      checkOutput("bs_a", 32'(bcd_digits), 32'h04);
      pressKey(4'h5);
      checkOutput("bs_b", 32'(bcd_digits), 32'h45);
      pressKey(4'hE);
      checkOutput("bs_c", 32'(bcd_digits), 32'h04);
      pressKey(4'h7);
      checkOutput("bs_d", 32'(bcd_digits), 32'h47);
      pressKey(4'hF);
      waitValid(lat);
      checkOutput("val_47", 32'(num_value), 32'd47);

      pressKey(4'h3); pressKey(4'hA); pressKey(4'hF);
      sawValid = 0;
      for (int k = 0; k < 6; k++) begin
         applyStimulus(1'b0, 4'h0, 1'b0);
         if (num_valid) sawValid = 1;
      end
      checkOutput("clr_novalid", 32'(sawValid), 32'd0);
      checkOutput("clr_keep", 32'(num_value), 32'd47);

      pressKey(4'h1); pressKey(4'h2); pressKey(4'hF);
      applyStimulus(1'b0, 4'h0, 1'b1);
      sawValid = 0;
      for (int k = 0; k < 5; k++) begin
         applyStimulus(1'b0, 4'h0, 1'b0);
         if (num_valid) sawValid = 1;
      end
      checkOutput("abort_novalid", 32'(sawValid), 32'd0);
      checkOutput("abort_value", 32'(num_value), 32'd0);
      pressKey(4'h5); pressKey(4'hF);
      waitValid(lat);
      checkOutput("val_5", 32'(num_value), 32'd5);

      pressKey(4'hB); pressKey(4'h2); pressKey(4'h5); pressKey(4'hF);
      waitValid(lat);
`ifdef SIGNED_ENTRY_EN
      checkOutput("neg25_val", 32'(num_value), 32'h3FE7);
      checkOutput("neg25_neg", 32'(num_neg), 32'd1);
`else
      checkOutput("b25_val", 32'(num_value), 32'd25);
      checkOutput("b25_neg", 32'(num_neg), 32'd0);
`endif

      for (int n = 0; n < 3000; n++) begin
         r = int'($urandom_range(0, 99));
         if (r == 0)
            applyStimulus(1'b0, 4'h0, 1'b1);
         else if (r < 55)
            applyStimulus(1'b1, 4'($urandom_range(0, 15)), 1'b0);
         else
            applyStimulus(1'b0, 4'($urandom_range(0, 15)), 1'b0);
      end

      $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
      $finish;
   end

endmodule
